paddle_io_latch: RTL and testbench
==================================

Name: paddle_io_latch

Overview:
- Memory-mapped input peripheral on the 8-bit CPU data bus, upstream of the game CPU. It feeds the CPU's read mux alongside RAM, ROM and the CRT registers.
- Digitizes both paddles in hardware. On the first rising edge of each paddle comparator per frame, it samples vpos.
- At vsync it commits clamped positions, validity flags and a frame counter into read registers.
- Game code no longer busy-polls IN_FLAGS for paddle edges.

Parameters:
- BASE_ADDR, 8'h44: address of register 0; the block decodes 4 consecutive addresses.
- X_MIN, 8'd16: lower clamp for the captured horizontal paddle value.
- X_MAX, 8'd224: upper clamp for the horizontal value.
- Y_MIN, 8'd0: lower clamp for the vertical paddle value.
- Y_MAX, 8'd239: upper clamp for the vertical value.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset; state resets on the clk edge where reset==0
- vpos  in  9  CRT vertical position from hvsync_generator
- vsync  in  1  vertical sync from hvsync_generator
- hpaddle  in  1  horizontal paddle comparator, asynchronous
- vpaddle  in  1  vertical paddle comparator, asynchronous
- address  in  8  CPU address bus
- data_in  in  8  CPU write data (CPU data_out)
- write  in  1  CPU write enable
- data_out  out  8  read data; combinational from address
- selected  out  1  high when address is in BASE_ADDR..BASE_ADDR+3; gates the top-level read mux

Behaviour:
- Register map (offset from BASE_ADDR):
  - 0 PADX: committed horizontal value.
  - 1 PADY: committed vertical value.
  - 2 STATUS: {5'b0, frame_tick, vvalid, hvalid}.
  - 3 FRAMES: 8-bit frame counter.
  - Out-of-range addresses: data_out=8'h00, selected=0.
- Reset (reset==0 at a clk edge):
  - PADX=X_MIN, PADY=Y_MIN, STATUS=0, FRAMES=0.
  - Both captured flags cleared; sync flops and edge history cleared to 0.
  - Reset overrides every other event, including mid-frame. After release, the first frame captures normally.
- Input synchronization:
  - hpaddle, vpaddle and vsync each pass through a 2-flop synchronizer plus one history flop.
  - A rise is detected when stage2==1 and history==0.
  - Latency: if the input is first high at edge k, it enters stage1 at edge k and stage2 at edge k+1. The rise is acted on at edge k+2 using the vpos present at edge k+2.
- Capture, per paddle, independent:
  - State ARMED: on a synced rise, load the pending value and set captured=1. The block then ignores further rises until the next commit.
  - Saturation: the 9-bit vpos saturates to 8'hFF if vpos>=256, else vpos[7:0].
  - Clamp: pending = max(MIN, min(MAX, saturated)).
- Commit, on synced vsync rise:
  - If captured, PADx<=pending and valid<=1; otherwise PADx holds its old value and valid<=0.
  - FRAMES<=FRAMES+1, wrapping 255->0.
  - frame_tick<=1.
  - Both captured flags clear, returning both paddles to ARMED.
- Same-cycle paddle rise and vsync rise:
  - The commit uses the state from before this edge, so this rise does not appear in the current commit.
  - The rise then captures into the new frame; captured=1 after the edge.
- CPU write to STATUS (write==1, address==BASE_ADDR+2) is write-1-to-clear:
  - data_in[0] clears hvalid, [1] clears vvalid, [2] clears frame_tick.
  - If a commit sets a bit on the same edge, set wins.
- Writes to offsets 0, 1 and 3 are ignored. Writes outside the range are ignored; RAM handles them.
- data_out has no read side effects. It reflects register state after the most recent clk edge, with zero-cycle read latency.

Test Plan:
- Reset: hold reset=0 for 2 clks with toggling paddles, then read the 4 registers -> PADX=16, PADY=0, STATUS=0, FRAMES=0.
- Basic capture: hpaddle rises while vpos=100 stays stable for 5 clks, vpaddle rises at vpos=50, then vsync pulses -> PADX=100, PADY=50, STATUS=8'h07, FRAMES=1.
- Clamp and saturate: hpaddle rise at vpos=5, vpaddle rise at vpos=260, then vsync -> PADX=16, PADY=239. Second frame with hpaddle at vpos=230 -> PADX=224.
- Missing paddle: frame with only vpaddle at vpos=70, then vsync -> PADX holds its prior value, STATUS=8'h06. A second hpaddle rise in one frame (vpos=10, then 90) -> first wins, PADX=16 (clamped 10).
- W1C vs set: write 8'h04 to STATUS on the same edge as a vsync commit -> frame_tick stays 1. Write 8'h07 on a later idle cycle -> STATUS=0 next cycle. Write 8'h55 to FRAMES -> unchanged.
- Wrap and mid-frame reset: 256 vsync pulses -> FRAMES=0. Capture vpos=120, assert reset for 1 clk before vsync, then vsync -> PADX=16, hvalid=0, FRAMES=1.

Source files
------------

// File: rtl/paddle_io_latch_if.sv
// CPU-side bus for the paddle I/O latch: address, write data and write strobe in,
// read data and address-hit indication out.
interface paddle_io_latch_if;
  logic [7:0] address;
  logic [7:0] data_in;
  logic       write;
  logic [7:0] data_out;
  logic       selected;

  modport master (
    output address,
    output data_in,
    output write,
    input  data_out,
    input  selected
  );

  modport slave (
    input  address,
    input  data_in,
    input  write,
    output data_out,
    output selected
  );
endinterface

// File: rtl/paddle_io_latch.sv
// Paddle digitizer: samples vpos on the first synced paddle edge of each frame and
// commits clamped positions, validity flags and a frame count at vsync.
module paddle_io_latch #(
  parameter logic [7:0] BASE_ADDR = 8'h44,
  parameter logic [7:0] X_MIN     = 8'd16,
  parameter logic [7:0] X_MAX     = 8'd224,
  parameter logic [7:0] Y_MIN     = 8'd0,
  parameter logic [7:0] Y_MAX     = 8'd239
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [8:0]       vpos,
  input  logic             vsync,
  input  logic             hpaddle,
  input  logic             vpaddle,
  paddle_io_latch_if.slave bus
);

  typedef enum logic {
    ARMED    = 1'b0,
    CAPTURED = 1'b1
  } cap_state_t;

  cap_state_t h_state, h_state_next;
  cap_state_t v_state, v_state_next;

  logic [1:0] h_sync, v_sync, vs_sync;
  logic       h_hist, v_hist, vs_hist;
  logic       h_rise, v_rise, vs_rise;
  logic       h_load, v_load;

  logic [7:0] h_pending, v_pending;
  logic [7:0] padx, pady, frames;
  logic       hvalid, vvalid, frame_tick;

  logic [7:0] saturated;
  logic [7:0] x_clamped, y_clamped;
  logic [7:0] offset;
  logic       status_wr;
  logic       unused_data_bits;

  // Paddle comparators and vsync are asynchronous to clk; two flops for
  // metastability, a third to remember the previous synced level.
  always_ff @(posedge clk) begin
    if (!reset) begin
      h_sync  <= 2'b00;
      v_sync  <= 2'b00;
      vs_sync <= 2'b00;
      h_hist  <= 1'b0;
      v_hist  <= 1'b0;
      vs_hist <= 1'b0;
    end else begin
      h_sync  <= {h_sync[0], hpaddle};
      v_sync  <= {v_sync[0], vpaddle};
      vs_sync <= {vs_sync[0], vsync};
      h_hist  <= h_sync[1];
      v_hist  <= v_sync[1];
      vs_hist <= vs_sync[1];
    end
  end

  assign h_rise  = h_sync[1]  & ~h_hist;
  assign v_rise  = v_sync[1]  & ~v_hist;
  assign vs_rise = vs_sync[1] & ~vs_hist;

  assign saturated = vpos[8] ? 8'hFF : vpos[7:0];

  always_comb begin
    x_clamped = saturated;
    if (saturated < X_MIN)
      x_clamped = X_MIN;
    else if (saturated > X_MAX)
      x_clamped = X_MAX;

    y_clamped = saturated;
    if (saturated < Y_MIN)
      y_clamped = Y_MIN;
    else if (saturated > Y_MAX)
      y_clamped = Y_MAX;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      h_state <= ARMED;
      v_state <= ARMED;
    end else begin
      h_state <= h_state_next;
      v_state <= v_state_next;
    end
  end

  // A commit re-arms both paddles, but a rise on the commit edge already
  // belongs to the new frame and captures immediately.
  always_comb begin
    h_state_next = h_state;
    v_state_next = v_state;
    h_load       = 1'b0;
    v_load       = 1'b0;

    if (vs_rise) begin
      h_state_next = h_rise ? CAPTURED : ARMED;
      h_load       = h_rise;
    end else if (h_state == ARMED && h_rise) begin
      h_state_next = CAPTURED;
      h_load       = 1'b1;
    end

    if (vs_rise) begin
      v_state_next = v_rise ? CAPTURED : ARMED;
      v_load       = v_rise;
    end else if (v_state == ARMED && v_rise) begin
      v_state_next = CAPTURED;
      v_load       = 1'b1;
    end
  end

  assign offset    = bus.address - BASE_ADDR;
  assign status_wr = bus.write && bus.selected && (offset[1:0] == 2'd2);

  // Status bits are write-1-to-clear; a commit on the same edge takes priority.
  always_ff @(posedge clk) begin
    if (!reset) begin
      h_pending  <= X_MIN;
      v_pending  <= Y_MIN;
      padx       <= X_MIN;
      pady       <= Y_MIN;
      hvalid     <= 1'b0;
      vvalid     <= 1'b0;
      frame_tick <= 1'b0;
      frames     <= 8'd0;
    end else begin
      if (h_load)
        h_pending <= x_clamped;
      if (v_load)
        v_pending <= y_clamped;

      if (vs_rise) begin
        if (h_state == CAPTURED)
          padx <= h_pending;
        if (v_state == CAPTURED)
          pady <= v_pending;
        hvalid     <= (h_state == CAPTURED);
        vvalid     <= (v_state == CAPTURED);
        frame_tick <= 1'b1;
        frames     <= frames + 8'd1;
      end else if (status_wr) begin
        if (bus.data_in[0])
          hvalid <= 1'b0;
        if (bus.data_in[1])
          vvalid <= 1'b0;
        if (bus.data_in[2])
          frame_tick <= 1'b0;
      end
    end
  end

  assign bus.selected = (offset[7:2] == 6'd0);

  always_comb begin
    bus.data_out = 8'h00;
    if (bus.selected) begin
      case (offset[1:0])
        2'd0:    bus.data_out = padx;
        2'd1:    bus.data_out = pady;
        2'd2:    bus.data_out = {5'b0, frame_tick, vvalid, hvalid};
        default: bus.data_out = frames;
      endcase
    end
  end

  assign unused_data_bits = &{1'b0, bus.data_in[7:3]};

endmodule

// File: tb/tb_paddle_io_latch.sv
// Directed-vector bench for paddle_io_latch: drives paddles, vsync and CPU writes on
// the falling edge and compares register reads against hand-computed values.
module tb_paddle_io_latch;

  localparam logic [7:0] BASE = 8'h44;

  logic       clk;
  logic       reset;
  logic [8:0] vpos;
  logic       vsync;
  logic       hpaddle;
  logic       vpaddle;

  int vectors;
  int miscompares;

  paddle_io_latch_if bus ();

  paddle_io_latch dut (
    .clk     (clk),
    .reset   (reset),
    .vpos    (vpos),
    .vsync   (vsync),
    .hpaddle (hpaddle),
    .vpaddle (vpaddle),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 8'h%02h, expected 8'h%02h", tag, observed, expected);
    end
  endtask

  task automatic checkReg(input logic [7:0] off, input logic [7:0] expected, input string tag);
    bus.address = BASE + off;
    #1;
    checkOutput(tag, bus.data_out, expected);
  endtask

  task automatic checkAll(input logic [7:0] px, input logic [7:0] py, input logic [7:0] st,
                          input logic [7:0] fr, input string tag);
    checkReg(8'd0, px, {tag, "_padx"});
    checkReg(8'd1, py, {tag, "_pady"});
    checkReg(8'd2, st, {tag, "_status"});
    checkReg(8'd3, fr, {tag, "_frames"});
  endtask

  // Rise lands on the first posedge after the falling edge; vpos held well past k+2.
  task automatic capturePaddle(input bit is_v, input logic [8:0] pos);
    @(negedge clk);
    vpos = pos;
    if (is_v) vpaddle = 1'b1;
    else      hpaddle = 1'b1;
    repeat (4) @(negedge clk);
    hpaddle = 1'b0;
    vpaddle = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic pulseVsync();
    @(negedge clk);
    vsync = 1'b1;
    repeat (2) @(negedge clk);
    vsync = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [7:0] off, input logic [7:0] value);
    @(negedge clk);
    bus.address = BASE + off;
    bus.data_in = value;
    bus.write   = 1'b1;
    @(negedge clk);
    bus.write   = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b0;
    vpos        = 9'd0;
    vsync       = 1'b0;
    hpaddle     = 1'b0;
    vpaddle     = 1'b0;
    bus.address = BASE;
    bus.data_in = 8'h00;
    bus.write   = 1'b0;

    // Reset with the paddles toggling underneath it
    @(negedge clk);
    hpaddle = 1'b1; vpaddle = 1'b1; vpos = 9'd77;
    @(negedge clk);
    hpaddle = 1'b0; vpaddle = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checkAll(8'd16, 8'd0, 8'h00, 8'd0, "reset");
    bus.address = BASE + 8'd4;
    #1;
    checkOutput("oor_hi_data", bus.data_out, 8'h00);
    checkOutput("oor_hi_sel", {7'b0, bus.selected}, 8'h00);
    bus.address = BASE - 8'd1;
    #1;
    checkOutput("oor_lo_sel", {7'b0, bus.selected}, 8'h00);
    bus.address = BASE + 8'd3;
    #1;
    checkOutput("in_range_sel", {7'b0, bus.selected}, 8'h01);

    // Basic capture
    capturePaddle(1'b0, 9'd100);
    capturePaddle(1'b1, 9'd50);
    pulseVsync();
    checkAll(8'd100, 8'd50, 8'h07, 8'd1, "basic");

    // Clamp low, saturate then clamp high, then horizontal clamp high
    capturePaddle(1'b0, 9'd5);
    capturePaddle(1'b1, 9'd260);
    pulseVsync();
    checkAll(8'd16, 8'd239, 8'h07, 8'd2, "clamp");
    capturePaddle(1'b0, 9'd230);
    pulseVsync();
    checkAll(8'd224, 8'd239, 8'h05, 8'd3, "xmax");

    // Missing paddle holds its value; first rise in a frame wins
    capturePaddle(1'b1, 9'd70);
    pulseVsync();
    checkAll(8'd224, 8'd70, 8'h06, 8'd4, "missing");
    capturePaddle(1'b0, 9'd10);
    capturePaddle(1'b0, 9'd90);
    pulseVsync();
    checkAll(8'd16, 8'd70, 8'h05, 8'd5, "firstwins");

    // Write-1-to-clear, and set beating clear on a commit edge
    applyStimulus(8'd2, 8'h07);
    checkReg(8'd2, 8'h00, "w1c_idle");
    capturePaddle(1'b0, 9'd150);
    @(negedge clk);
    vsync = 1'b1;
    repeat (2) @(negedge clk);
    vsync       = 1'b0;
    bus.address = BASE + 8'd2;
    bus.data_in = 8'h07;
    bus.write   = 1'b1;
    @(negedge clk);
    bus.write = 1'b0;
    repeat (2) @(negedge clk);
    checkAll(8'd150, 8'd70, 8'h05, 8'd6, "setwins");
    applyStimulus(8'd2, 8'h04);
    checkReg(8'd2, 8'h01, "w1c_tick");
    applyStimulus(8'd2, 8'h07);
    checkReg(8'd2, 8'h00, "w1c_all");
    applyStimulus(8'd3, 8'h55);
    checkReg(8'd3, 8'd6, "ro_frames");
    applyStimulus(8'd0, 8'h33);
    checkReg(8'd0, 8'd150, "ro_padx");

    // Frame counter wrap
    for (int i = 0; i < 249; i++) pulseVsync();
    checkReg(8'd3, 8'd255, "frames_255");
    pulseVsync();
    checkAll(8'd150, 8'd70, 8'h04, 8'd0, "wrap");

    // Reset between a capture and its commit
    capturePaddle(1'b0, 9'd120);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    checkAll(8'd16, 8'd0, 8'h00, 8'd0, "midreset");
    pulseVsync();
    checkAll(8'd16, 8'd0, 8'h04, 8'd1, "postreset");

    // Paddle rise on the commit edge goes into the next frame
    @(negedge clk);
    vpos    = 9'd180;
    hpaddle = 1'b1;
    vsync   = 1'b1;
    repeat (4) @(negedge clk);
    hpaddle = 1'b0;
    vsync   = 1'b0;
    repeat (3) @(negedge clk);
    checkAll(8'd16, 8'd0, 8'h04, 8'd2, "samecycle");
    pulseVsync();
    checkAll(8'd180, 8'd0, 8'h05, 8'd3, "nextframe");

    // Write outside the decoded window must not touch STATUS
    applyStimulus(8'd4, 8'h07);
    checkReg(8'd2, 8'h05, "oor_write");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
